// File: rtl/csm51a_coin_pkg.sv
// Shared types and constants for the coin transmitter: coin codes, FSM states, credit helpers.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package csm51a_coin_pkg;

  localparam int CREDIT_W = 4;

  localparam logic [1:0] CODE_NONE   = 2'b00;
  localparam logic [1:0] CODE_NICKEL = 2'b01;
  localparam logic [1:0] CODE_DIME   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  // coin_type 1 is a dime, 0 a nickel
  function automatic logic [1:0] coin_code(input logic ctype);
    return ctype ? CODE_DIME : CODE_NICKEL;
  endfunction

  // Value in 5-cent units
  function automatic logic [CREDIT_W-1:0] coin_value(input logic ctype);
    return ctype ? CREDIT_W'(2) : CREDIT_W'(1);
  endfunction

  // Saturating add so credit pins at all-ones rather than wrapping
  function automatic logic [CREDIT_W-1:0] credit_add(input logic [CREDIT_W-1:0] a,
                                                     input logic [CREDIT_W-1:0] b);
    logic [CREDIT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CREDIT_W] ? {CREDIT_W{1'b1}} : s[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/csm51a_coin_tx_if.sv
// Bundle between coin sensor / vending FSM and the coin transmitter.
// Latency: wires only.
// Backpressure: coin_ready from the transmitter gates coin_valid.
interface csm51a_coin_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  import csm51a_coin_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                coin_valid;
  logic                coin_type;
  logic                coin_ready;
  logic                hold;
  logic                vend;
  logic                x1;
  logic                x0;
  logic [CREDIT_W-1:0] credit;
  logic [CW-1:0]       fifo_count;

  modport master (
    output coin_valid, coin_type, hold, vend,
    input  coin_ready, x1, x0, credit, fifo_count
  );

  modport slave (
    input  coin_valid, coin_type, hold, vend,
    output coin_ready, x1, x0, credit, fifo_count
  );

endinterface

// File: rtl/csm51a_coin_fifo.sv
// Small power-of-two FIFO holding queued coin types in acceptance order.
// Latency: pushed entry visible at head one edge after the push; head read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; caller watches full/empty.
module csm51a_coin_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign data    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; emptiness is tracked by count alone
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/csm51a_coin_tx.sv
// Queues sensed coins and sends each as a one-cycle {x1,x0} code to the vending FSM, tracking credit.
// Latency: coin accepted at edge N into an idle, empty block appears on x1/x0 after edge N+1.
// Backpressure: coin_ready drops when the queue is full; hold stalls dequeue without aborting a send.
module csm51a_coin_tx
  import csm51a_coin_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  csm51a_coin_tx_if.slave   bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t           state;
  tx_state_t           state_nxt;
  logic                push;
  logic                pop;
  logic                can_pop;
  logic                gap_last;
  logic                fifo_full;
  logic                fifo_empty;
  logic                head_type;
  logic [CW-1:0]       cnt;
  logic [1:0]          code_q;
  logic [1:0]          code_out;
  logic [GW-1:0]       gap_cnt;
  logic [CREDIT_W-1:0] credit_q;

  // Ready comes from the registered count only, so a same-cycle pop never opens a slot early
  assign bus.coin_ready = !fifo_full;
  assign push           = bus.coin_valid && !fifo_full;
  assign can_pop        = !fifo_empty && !bus.hold;
  assign gap_last       = (gap_cnt == GAP_LAST);

  csm51a_coin_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.coin_type),
    .pop   (pop),
    .data  (head_type),
    .count (cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: every dequeue decision uses the same IDLE rule (non-empty and not held)
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = can_pop ? SEND : IDLE;
      SEND: begin
        if (GAP_CYCLES > 0) state_nxt = GAP;
        else                state_nxt = can_pop ? SEND : IDLE;
      end
      GAP: begin
        if (gap_last) state_nxt = can_pop ? SEND : IDLE;
        else          state_nxt = GAP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: a pop happens exactly when the FSM is about to enter SEND
  always_comb begin
    pop      = (state_nxt == SEND);
    code_out = (state == SEND) ? code_q : CODE_NONE;
  end

  assign bus.x1         = code_out[1];
  assign bus.x0         = code_out[0];
  assign bus.credit     = credit_q;
  assign bus.fifo_count = cnt;

  // Latch the code of the coin leaving the queue; only ever NICKEL or DIME
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   code_q <= CODE_NONE;
    else if (pop) code_q <= coin_code(head_type);
  end

  // Gap counter restarts on each send and counts the idle cycles that follow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               gap_cnt <= '0;
    else if (state == SEND)   gap_cnt <= '0;
    else if (state == GAP)    gap_cnt <= gap_cnt + 1'b1;
  end

  // Credit: vend restarts from the coin entering SEND on the same edge, otherwise accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        credit_q <= '0;
    else if (bus.vend) credit_q <= pop ? coin_value(head_type) : '0;
    else if (pop)      credit_q <= credit_add(credit_q, coin_value(head_type));
  end

endmodule

// File: tb/tb_csm51a_coin_tx.sv
// Bench for csm51a_coin_tx: table of per-cycle vectors plus a code scoreboard, and hand sequences
// for reset-in-flight and the gap variant.
module tb_csm51a_coin_tx;
  import csm51a_coin_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csm51a_coin_tx_if #(.FIFO_DEPTH(4)) bus0 ();
  csm51a_coin_tx_if #(.FIFO_DEPTH(4)) bus2 ();

  csm51a_coin_tx #(.FIFO_DEPTH(4), .GAP_CYCLES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  csm51a_coin_tx #(.FIFO_DEPTH(4), .GAP_CYCLES(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  typedef struct {
    bit         valid;
    bit         ctype;
    bit         hold;
    bit         vend;
    logic [1:0] x;
    logic [3:0] credit;
    logic [2:0] count;
    logic       ready;
  } vec_t;

  int         n_chk  = 0;
  int         n_fail = 0;
  bit         sb_q[$];
  logic [2:0] mdl_cnt = 3'd0;
  vec_t       tbl[$];

  function automatic vec_t mk(bit v, bit t, bit h, bit vd, logic [1:0] x, int cr, int cn, bit rdy);
    vec_t r;
    r.valid  = v;
    r.ctype  = t;
    r.hold   = h;
    r.vend   = vd;
    r.x      = x;
    r.credit = cr[3:0];
    r.count  = cn[2:0];
    r.ready  = rdy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on dut0, then check scoreboard and table expectations after the edge
  task automatic step0(input vec_t r, input int row);
    bit acc;
    bit exp_t;
    bus0.coin_valid = r.valid;
    bus0.coin_type  = r.ctype;
    bus0.hold       = r.hold;
    bus0.vend       = r.vend;
    acc = r.valid && (mdl_cnt < 3'd4);
    @(posedge clk);
    #1;
    if (acc) sb_q.push_back(r.ctype);
    mdl_cnt = r.count;
    if ({bus0.x1, bus0.x0} != CODE_NONE) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow row %0d: got code %b, expected no coin", row, {bus0.x1, bus0.x0});
      end else begin
        exp_t = sb_q.pop_front();
        chk($sformatf("sb_code row %0d", row), {30'd0, bus0.x1, bus0.x0}, {30'd0, coin_code(exp_t)});
      end
    end
    chk($sformatf("x row %0d", row),      {30'd0, bus0.x1, bus0.x0}, {30'd0, r.x});
    chk($sformatf("credit row %0d", row), {28'd0, bus0.credit},      {28'd0, r.credit});
    chk($sformatf("count row %0d", row),  {29'd0, bus0.fifo_count},  {29'd0, r.count});
    chk($sformatf("ready row %0d", row),  {31'd0, bus0.coin_ready},  {31'd0, r.ready});
  endtask

  initial begin
    logic [1:0] gx [6];

    // Main table for the back-to-back (no gap) instance
    //               v  t  h  vd  x      cr cn rdy
    // dime, nickel, dime on consecutive cycles
    tbl.push_back(mk(1, 1, 0, 0, 2'b00, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 2'b11, 2, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 2'b01, 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'b11, 5, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 5, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2'b00, 0, 0, 1));
    // four nickels then vend
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 2'b01, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 2'b01, 2, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 2'b01, 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'b01, 4, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2'b00, 0, 0, 1));
    // hold: fill to four, fifth refused, release with a refused offer while full
    tbl.push_back(mk(1, 1, 1, 0, 2'b00, 0, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0, 2'b00, 0, 2, 1));
    tbl.push_back(mk(1, 1, 1, 0, 2'b00, 0, 3, 1));
    tbl.push_back(mk(1, 0, 1, 0, 2'b00, 0, 4, 0));
    tbl.push_back(mk(1, 1, 1, 0, 2'b00, 0, 4, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2'b11, 2, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'b01, 3, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'b11, 5, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'b01, 6, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 6, 0, 1));
    // reach credit 7, then vend on the edge a dime enters SEND
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 6, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 2'b01, 7, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2, 0, 1));

    // Reset asserted with a coin offered: nothing may be accepted
    rst_n           = 1'b0;
    bus0.coin_valid = 1'b1;
    bus0.coin_type  = 1'b1;
    bus0.hold       = 1'b0;
    bus0.vend       = 1'b0;
    bus2.coin_valid = 1'b0;
    bus2.coin_type  = 1'b0;
    bus2.hold       = 1'b0;
    bus2.vend       = 1'b0;
    #2;
    chk("reset x",      {30'd0, bus0.x1, bus0.x0}, 32'd0);
    chk("reset credit", {28'd0, bus0.credit},      32'd0);
    chk("reset count",  {29'd0, bus0.fifo_count},  32'd0);
    chk("reset ready",  {31'd0, bus0.coin_ready},  32'd1);
    @(posedge clk);
    #1;
    chk("reset no accept", {29'd0, bus0.fifo_count}, 32'd0);
    #2;
    bus0.coin_valid = 1'b0;
    rst_n           = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step0(tbl[i], i);

    // Two dimes queued, reset while the first is in SEND
    step0(mk(1, 1, 0, 0, 2'b00, 2, 1, 1), 100);
    step0(mk(1, 1, 0, 0, 2'b11, 4, 1, 1), 101);
    bus0.coin_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset x",      {30'd0, bus0.x1, bus0.x0}, 32'd0);
    chk("midreset credit", {28'd0, bus0.credit},      32'd0);
    chk("midreset count",  {29'd0, bus0.fifo_count},  32'd0);
    chk("midreset ready",  {31'd0, bus0.coin_ready},  32'd1);
    sb_q.delete();
    mdl_cnt = 3'd0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step0(mk(0, 0, 0, 0, 2'b00, 0, 0, 1), 110 + i);
    chk("sb drained", sb_q.size(), 32'd0);

    // Gap variant: two nickels queued under hold, then released
    bus2.hold       = 1'b1;
    bus2.coin_valid = 1'b1;
    bus2.coin_type  = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("gap queued count", {29'd0, bus2.fifo_count}, 32'd2);
    bus2.coin_valid = 1'b0;
    bus2.hold       = 1'b0;
    gx = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("gap x cycle %0d", i), {30'd0, bus2.x1, bus2.x0}, {30'd0, gx[i]});
    end
    chk("gap credit", {28'd0, bus2.credit},     32'd2);
    chk("gap count",  {29'd0, bus2.fifo_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csm51a_coin_tx.md
CSM51A_COIN_TX -- requirements
Module: csm51a_coin_tx

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, coin queue depth (power of 2, minimum 2).
REQ-002 Parameter: GAP_CYCLES, default 0, idle (00) cycles forced after each transmitted coin.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 coin_valid  input  1  coin sensor offers a coin this cycle.
REQ-006 coin_type  input  1  coin value: 0 = nickel, 1 = dime; meaningful only with coin_valid.
REQ-007 coin_ready  output  1  block can accept a coin this cycle.
REQ-008 hold  input  1  when high, no new coin is dequeued.
REQ-009 vend  input  1  vending FSM dispense pulse; clears credit.
REQ-010 x1  output  1  coin code high bit to the vending FSM.
REQ-011 x0  output  1  coin code low bit to the vending FSM.
REQ-012 credit  output  4  credit sent since the last vend, in units of 5 cents.
REQ-013 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued coins.

Function
REQ-014 Coin code {x1,x0} SHALL be: 00 none, 01 nickel, 11 dime; 10 SHALL never be driven.
REQ-015 A coin SHALL be accepted on a rising edge where coin_valid && coin_ready.
REQ-016 coin_ready SHALL be high iff fifo_count < FIFO_DEPTH, computed from registered count only; a pop in the same cycle does not raise it.
REQ-017 The FIFO SHALL hold coins in acceptance order; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-018 The transmit FSM SHALL have states IDLE, SEND and GAP.
REQ-019 IDLE->SEND: on an edge where the FIFO is non-empty and hold is low, one coin SHALL be popped and its code registered onto x1/x0.
REQ-020 SEND SHALL last exactly one cycle and drive the code of the popped coin.
REQ-021 From SEND: if GAP_CYCLES > 0, go to GAP; otherwise pop the next coin back-to-back when it is available and hold is low, else go to IDLE.
REQ-022 GAP SHALL drive 00 for exactly GAP_CYCLES cycles, then apply the IDLE rules.
REQ-023 x1/x0 SHALL be 00 in IDLE and GAP.
REQ-024 Latency: a coin accepted at edge N into an empty FIFO with the FSM in IDLE and hold low SHALL appear on x1/x0 in the cycle after edge N+1.
REQ-025 hold SHALL be sampled only at dequeue decisions; a coin already in SEND SHALL complete.
REQ-026 Credit update per edge:
  - vend high: credit becomes the value of the coin entering SEND at that edge (0 if none).
  - otherwise: credit += 1 for a nickel or 2 for a dime, at the edge the coin enters SEND.
  - credit saturates at 15.
REQ-027 vend SHALL NOT flush the FIFO or alter the FSM state.

Reset
REQ-028 While rst_n is low, the block SHALL immediately force:
  - FSM = IDLE
  - FIFO empty, fifo_count = 0
  - x1 = 0, x0 = 0
  - credit = 0
  - coin_ready = 1
REQ-029 Reset mid-operation SHALL discard queued coins and any partial gap; none SHALL be transmitted after release.
REQ-030 The first acceptance SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-031 Package csm51a_coin_pkg SHALL hold:
  - the coin code constants CODE_NONE, CODE_NICKEL, CODE_DIME
  - the FSM state typedef
  - the credit width constant
REQ-032 The queue SHALL be a sub-module csm51a_coin_fifo (push, pop, data, count, full, empty), parameterised by FIFO_DEPTH.

Verification
REQ-033 Dime, nickel, dime offered on consecutive cycles, hold=0, GAP_CYCLES=0 -> x1x0 = 11, 01, 11 on consecutive cycles; credit = 2, 3, 5.
REQ-034 Four nickels, then a vend pulse -> four consecutive 01 codes; credit 1, 2, 3, 4, then 0 after vend.
REQ-035 hold=1, five coins offered -> four accepted, coin_ready low and fifth refused, fifo_count=4; release hold -> four codes in order, fifo_count reaches 0.
REQ-036 Two dimes queued, rst_n pulled low while the first is in SEND -> x1x0=00, credit=0, fifo_count=0 at once; no dime appears after release.
REQ-037 GAP_CYCLES=2, two nickels queued -> 01, 00, 00, 01; credit 2 when done.
REQ-038 vend asserted on the edge a dime enters SEND with credit=7 -> credit = 2.
